// File: rtl/branch_unit_if.sv
// Decode-to-branch-unit bus: branch requests in, PC and RAS status out.
interface branch_unit_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             step;
  logic             br_valid;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] test_value;
  logic [WIDTH-1:0] dest_address;
  logic [WIDTH-1:0] pc;
  logic             taken_o;
  logic             flush_o;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  // Decode/fetch side: issues branch requests, observes PC and status.
  modport master (
    output step, br_valid, br_op, test_value, dest_address,
    input  pc, taken_o, flush_o, ras_count, ras_overflow, ras_underflow
  );

  // Branch unit side.
  modport slave (
    input  step, br_valid, br_op, test_value, dest_address,
    output pc, taken_o, flush_o, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/branch_unit.sv
// Branch/PC unit: owns the PC, resolves conditional jumps, CALL/RET via a
// circular return-address stack, and raises a flush window after redirects.
module branch_unit #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      RAS_DEPTH    = 4,
  parameter int unsigned      FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
  input logic           clk,
  input logic           rst,
  branch_unit_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_JEZ  = 3'b001;
  localparam logic [2:0] OP_JNZ  = 3'b010;
  localparam logic [2:0] OP_JGZ  = 3'b011;
  localparam logic [2:0] OP_JLZ  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [FC_W-1:0]  flush_cnt;
  logic [WIDTH-1:0] pc_q;
  logic             taken_q;
  logic             flush_q;
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic             decide_c;
  logic             taken_c;
  logic             push_c;
  logic             pop_c;
  logic             under_c;
  logic [WIDTH-1:0] pc_inc_c;
  logic [WIDTH-1:0] target_c;

  // Branch decision: only in RUN on a stepped cycle with a valid request.
  always_comb begin
    decide_c = bus.step && bus.br_valid && (state == RUN);
    taken_c  = 1'b0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    under_c  = 1'b0;
    pc_inc_c = pc_q + WIDTH'(1);
    target_c = bus.dest_address;
    if (decide_c) begin
      case (bus.br_op)
        OP_JMP:  taken_c = 1'b1;
        OP_JEZ:  taken_c = (bus.test_value == '0);
        OP_JNZ:  taken_c = (bus.test_value != '0);
        // Signed > 0: sign bit clear and not zero.
        OP_JGZ:  taken_c = !bus.test_value[WIDTH-1] && (bus.test_value != '0);
        // Signed < 0: sign bit set.
        OP_JLZ:  taken_c = bus.test_value[WIDTH-1];
        OP_CALL: begin
          taken_c = 1'b1;
          push_c  = 1'b1;
        end
        OP_RET: begin
          if (count != '0) begin
            taken_c  = 1'b1;
            pop_c    = 1'b1;
            target_c = ras_mem[top];
          end else begin
            under_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, flush FSM, RAS pointer/count and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
      state       <= RUN;
      flush_cnt   <= '0;
      top         <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.step) begin
      taken_q <= taken_c;
      pc_q    <= taken_c ? target_c : pc_inc_c;

      // A full-stack push overwrites the oldest entry; count saturates.
      if (push_c) begin
        top <= top + PTR_W'(1);
        if (count == CNT_W'(RAS_DEPTH)) begin
          overflow_q <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
      if (pop_c) begin
        top   <= top - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
      if (under_c) begin
        underflow_q <= 1'b1;
      end

      case (state)
        RUN: begin
          if (taken_c) begin
            state     <= FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            flush_q   <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end else begin
      taken_q <= 1'b0;
    end
  end

  // RAS storage: written with the return address on every CALL.
  always_ff @(posedge clk) begin
    if (!rst && bus.step && push_c) begin
      ras_mem[top + PTR_W'(1)] <= pc_inc_c;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.taken_o       = taken_q;
  assign bus.flush_o       = flush_q;
  assign bus.ras_count     = count;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_branch_unit;

  localparam int unsigned WIDTH        = 16;
  localparam int unsigned RAS_DEPTH    = 4;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [15:0] RESET_PC     = 16'h0000;

  localparam logic [2:0] JMP = 3'd0, JEZ = 3'd1, JNZ = 3'd2, JGZ = 3'd3,
                         JLZ = 3'd4, CALL = 3'd5, RET = 3'd6, NOP = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

  branch_unit #(
    .WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: PC value, remaining flush cycles, RAS as a queue
  // (back = newest). Updated on each rising edge from the applied inputs.
  logic [15:0] m_pc = '0;
  bit          m_taken = 1'b0;
  int          m_flush = 0;
  logic [15:0] m_ras [$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_tk;
  logic [15:0] m_tgt;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RESET_PC; m_taken = 1'b0; m_flush = 0;
      m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b1;
    end else if (bus.step) begin
      m_tk  = 1'b0;
      m_tgt = bus.dest_address;
      if (m_flush == 0 && bus.br_valid) begin
        case (bus.br_op)
          JMP: m_tk = 1'b1;
          JEZ: m_tk = (bus.test_value == 16'd0);
          JNZ: m_tk = (bus.test_value != 16'd0);
          JGZ: m_tk = ($signed(bus.test_value) > 16'sd0);
          JLZ: m_tk = ($signed(bus.test_value) < 16'sd0);
          CALL: begin
            m_tk = 1'b1;
            if (m_ras.size() == RAS_DEPTH) begin
              void'(m_ras.pop_front());
              m_ovf = 1'b1;
            end
            m_ras.push_back(16'(m_pc + 16'd1));
          end
          RET: begin
            if (m_ras.size() > 0) begin
              m_tk  = 1'b1;
              m_tgt = m_ras.pop_back();
            end else begin
              m_unf = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (m_flush > 0) m_flush--;
      if (m_tk) begin
        m_pc    = m_tgt;
        m_flush = FLUSH_CYCLES;
      end else begin
        m_pc = 16'(m_pc + 16'd1);
      end
      m_taken = m_tk;
    end else begin
      m_taken = 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc",            32'(bus.pc),            32'(m_pc));
      check("taken_o",       32'(bus.taken_o),       32'(m_taken));
      check("flush_o",       32'(bus.flush_o),       32'(m_flush > 0));
      check("ras_count",     32'(bus.ras_count),     32'(m_ras.size()));
      check("ras_overflow",  32'(bus.ras_overflow),  32'(m_ovf));
      check("ras_underflow", 32'(bus.ras_underflow), 32'(m_unf));
    end
  end

  // Apply one cycle of inputs and wait until its edge has settled.
  task automatic cyc(input logic s, input logic v, input logic [2:0] op,
                     input logic [15:0] tv, input logic [15:0] d);
    bus.step = s; bus.br_valid = v; bus.br_op = op;
    bus.test_value = tv; bus.dest_address = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, NOP, 16'h0, 16'h0);
  endtask

  logic [15:0] ret_exp [4] = '{16'h0051, 16'h0041, 16'h0031, 16'h0021};
  logic [15:0] rtv;

  initial begin
    bus.step = 1'b1; bus.br_valid = 1'b0; bus.br_op = NOP;
    bus.test_value = '0; bus.dest_address = '0;

    // Reset state and plain counting
    rst = 1'b1; idle(2);
    check("lit_reset_pc", 32'(bus.pc), 32'h0);
    check("lit_reset_flush", 32'(bus.flush_o), 32'h0);
    check("lit_reset_cnt", 32'(bus.ras_count), 32'h0);
    rst = 1'b0; idle(5);
    check("lit_t1_pc", 32'(bus.pc), 32'h5);
    check("lit_t1_taken", 32'(bus.taken_o), 32'h0);

    // Signed compares and flush window
    rst = 1'b1; idle(1); rst = 1'b0; idle(3);
    check("lit_t2_pc3", 32'(bus.pc), 32'h3);
    cyc(1, 1, JLZ, 16'hFFFF, 16'h0040);
    check("lit_t2_pc", 32'(bus.pc), 32'h40);
    check("lit_t2_taken", 32'(bus.taken_o), 32'h1);
    check("lit_t2_flush", 32'(bus.flush_o), 32'h1);
    idle(1);
    check("lit_t2_flush2", 32'(bus.flush_o), 32'h1);
    check("lit_t2_taken2", 32'(bus.taken_o), 32'h0);
    idle(1);
    check("lit_t2_flush_end", 32'(bus.flush_o), 32'h0);
    cyc(1, 1, JGZ, 16'h8000, 16'h0099);
    check("lit_t2_jgz_pc", 32'(bus.pc), 32'h43);

    // Requests during flush are ignored
    cyc(1, 1, JEZ, 16'h0000, 16'h0100);
    check("lit_t3_pc", 32'(bus.pc), 32'h100);
    cyc(1, 1, JMP, 16'h0, 16'h0200);
    cyc(1, 1, JMP, 16'h0, 16'h0200);
    check("lit_t3_ignored", 32'(bus.pc), 32'h102);
    cyc(1, 1, JMP, 16'h0, 16'h0200);
    check("lit_t3_jmp", 32'(bus.pc), 32'h200);
    idle(2);

    // RAS overflow and underflow
    cyc(1, 1, JMP, 16'h0, 16'h000E); idle(2);
    check("lit_t4_start", 32'(bus.pc), 32'h10);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, CALL, 16'h0, 16'(k * 16 + 14));
      idle(2);
    end
    check("lit_t4_pc", 32'(bus.pc), 32'h60);
    check("lit_t4_cnt", 32'(bus.ras_count), 32'h4);
    check("lit_t4_ovf", 32'(bus.ras_overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, RET, 16'h0, 16'h0);
      check("lit_t4_ret", 32'(bus.pc), 32'(ret_exp[i]));
      idle(2);
    end
    cyc(1, 1, RET, 16'h0, 16'h0);
    check("lit_t4_ret5_pc", 32'(bus.pc), 32'h24);
    check("lit_t4_unf", 32'(bus.ras_underflow), 32'h1);
    check("lit_t4_ret5_flush", 32'(bus.flush_o), 32'h0);

    // PC wrap and step=0 freeze during flush
    cyc(1, 1, JMP, 16'h0, 16'hFFFD); idle(2);
    check("lit_t5_ffff", 32'(bus.pc), 32'hFFFF);
    idle(1);
    check("lit_t5_wrap", 32'(bus.pc), 32'h0);
    cyc(1, 1, JMP, 16'h0, 16'hFFFF); idle(1);
    repeat (3) begin
      cyc(0, 1, JMP, 16'h0, 16'h1234);
      check("lit_t5_hold_pc", 32'(bus.pc), 32'h0);
      check("lit_t5_hold_flush", 32'(bus.flush_o), 32'h1);
    end
    idle(1);
    check("lit_t5_resume_pc", 32'(bus.pc), 32'h1);
    check("lit_t5_resume_flush", 32'(bus.flush_o), 32'h0);

    // Reset in the middle of a flush window
    cyc(1, 1, CALL, 16'h0, 16'h0300); idle(2);
    cyc(1, 1, CALL, 16'h0, 16'h0400);
    check("lit_t6_cnt", 32'(bus.ras_count), 32'h2);
    rst = 1'b1; idle(1);
    check("lit_t6_pc", 32'(bus.pc), 32'(RESET_PC));
    check("lit_t6_flush", 32'(bus.flush_o), 32'h0);
    check("lit_t6_cnt0", 32'(bus.ras_count), 32'h0);
    check("lit_t6_flags", 32'({bus.ras_overflow, bus.ras_underflow}), 32'h0);
    rst = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 4))
        0: rtv = 16'h0000;
        1: rtv = 16'hFFFF;
        2: rtv = 16'h8000;
        3: rtv = 16'h7FFF;
        default: rtv = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
          3'($urandom_range(0, 7)), rtv, 16'($urandom));
    end
    rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
